// File: rtl/instr_fetch_queue.sv
// Fetch stage: reads instruction words from a wait-state memory (req/ack) and queues {instr, pc}.
// Latency: an acked word is on instr_out the cycle after the ack; zero-wait memory sustains 1 instr/cycle.
// Backpressure: instr_ready=0 holds the head stable; fetch stops issuing once queued + outstanding reaches DEPTH.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   mem_req/mem_addr          read request and word address (fetch_pc[9:2], or the held address while draining)
//   mem_ack/mem_rdata         request accepted, data valid in the same cycle
//   redirect_valid/_pc        taken branch/jump: flush the queue and refetch from the target
//   instr_valid/_ready        head handshake towards the datapath; instr_out/instr_pc carry the head
//   fetch_pc                  PC of the next or outstanding request
//   queue_count               occupied entries
module instr_fetch_queue #(
  parameter int                   WORD_SIZE = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [7:0]               mem_addr,
  input  logic                     mem_ack,
  input  logic [WORD_SIZE-1:0]     mem_rdata,
  input  logic                     redirect_valid,
  input  logic [WORD_SIZE-1:0]     redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [WORD_SIZE-1:0]     instr_out,
  output logic [WORD_SIZE-1:0]     instr_pc,
  output logic [WORD_SIZE-1:0]     fetch_pc,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] pc;
  } entry_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [7:0]           drain_addr_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  entry_t               fifo_q [DEPTH];

  logic                 push;
  logic                 pop;
  logic [CNT_W-1:0]     count_after;
  logic                 room_after;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;

  // Occupancy once the word acked this cycle lands, crediting a same-cycle pop.
  assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);
  assign room_after  = (count_after < DEPTH_C);

  // ---------------------------------------------------------------------------
  // Fetch FSM: next state, request and push
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req    = 1'b0;
    push       = 1'b0;

    case (state_q)
      IDLE: begin
        // Nothing is outstanding here, so the only limit is free queue space.
        if (!redirect_valid && (count_q < DEPTH_C)) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + WORD_SIZE'(4);
            state_d    = room_after ? REQ : IDLE;
          end else begin
            state_d = REQ;
          end
        end
      end

      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + WORD_SIZE'(4);
          state_d    = room_after ? REQ : IDLE;
        end
      end

      DRAIN: begin
        // Stale request still in flight: wait it out and throw the data away.
        // The queue was flushed by the redirect, so there is always room afterwards.
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect beats everything but reset. An acked word in the same cycle is
    // dropped; an unacked outstanding request must still be drained.
    if (redirect_valid) begin
      push       = 1'b0;
      fetch_pc_d = redirect_pc & ~WORD_SIZE'(3);
      state_d    = (mem_req && !mem_ack) ? DRAIN : REQ;
    end

    // The memory is reset together with us, so nothing issued now is meaningful.
    if (rst) begin
      mem_req = 1'b0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC[9:2];
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      // Track the live address until draining starts; in DRAIN it keeps the
      // address of the stale request while fetch_pc already holds the target.
      if (state_q != DRAIN) begin
        drain_addr_q <= fetch_pc_q[9:2];
      end
    end
  end

  assign mem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q[9:2];
  assign fetch_pc = fetch_pc_q;

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      // Flush. A pop in this cycle has already been taken by the datapath.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{instr: mem_rdata, pc: fetch_pc_q};
    end
  end

  assign instr_out   = instr_valid ? fifo_q[rd_ptr_q].instr : '0;
  assign instr_pc    = instr_valid ? fifo_q[rd_ptr_q].pc    : '0;
  assign queue_count = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] fetch_pc;
  logic [2:0]  queue_count;

  // Second instance: reset PC near the 10-bit address wrap, zero-wait memory.
  logic        b_mem_req;
  logic [7:0]  b_mem_addr;
  logic        b_mem_ack;
  logic [31:0] b_mem_rdata;
  logic        b_instr_valid;
  logic [31:0] b_instr_out;
  logic [31:0] b_instr_pc;
  logic [31:0] b_fetch_pc;
  logic [2:0]  b_queue_count;
  logic        b_redirect_valid = 1'b0;
  logic [31:0] b_redirect_pc = '0;
  logic        b_instr_ready = 1'b1;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Memory model: acks after ws wait states, data = 0xCAFE0000 + word address.
  int ws = 0;
  int wcnt = 0;

  always #5 clk = ~clk;

  assign mem_ack     = mem_req && (wcnt == ws);
  assign mem_rdata   = 32'hCAFE_0000 + {24'h0, mem_addr};
  assign b_mem_ack   = b_mem_req;
  assign b_mem_rdata = 32'hCAFE_0000 + {24'h0, b_mem_addr};

  always_ff @(posedge clk) begin
    if (rst)                     wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                         wcnt <= 0;
  end

  instr_fetch_queue #(.WORD_SIZE(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .fetch_pc(fetch_pc), .queue_count(queue_count)
  );

  instr_fetch_queue #(.WORD_SIZE(32), .DEPTH(4), .RESET_PC(32'h3FC)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
    .instr_out(b_instr_out), .instr_pc(b_instr_pc),
    .fetch_pc(b_fetch_pc), .queue_count(b_queue_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset(input int wait_states, input logic ready);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    ws             = wait_states;
    instr_ready    = ready;
    nxt();
    nxt();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   32'(mem_req), 32'h0);
    check({tag, "_addr"},  32'(mem_addr), 32'h0);
    check({tag, "_fpc"},   fetch_pc, 32'h0);
    check({tag, "_vld"},   32'(instr_valid), 32'h0);
    check({tag, "_out"},   instr_out, 32'h0);
    check({tag, "_ipc"},   instr_pc, 32'h0);
    check({tag, "_cnt"},   32'(queue_count), 32'h0);
  endtask

  task automatic wait_addr(input logic [7:0] a, input int budget);
    int i;
    i = 0;
    while (!(mem_req && mem_addr == a) && i < budget) begin
      nxt();
      settle();
      i++;
    end
    check("wait_addr", 32'(mem_req && mem_addr == a), 32'h1);
  endtask

  task automatic wait_valid(input int budget);
    int i;
    i = 0;
    while (!instr_valid && i < budget) begin
      nxt();
      settle();
      i++;
    end
    check("wait_valid", 32'(instr_valid), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ack_cnt;

    // ---- T1/T5: zero-wait, ready=1, streaming; wrap instance alongside ----
    do_reset(0, 1'b1);
    settle();
    check_reset_vals("rst");
    check("b_rst_addr", 32'(b_mem_addr), 32'hFF);
    check("b_rst_req",  32'(b_mem_req), 32'h0);

    rst = 1'b0;
    settle();
    check("t1_c1_req",  32'(mem_req), 32'h1);
    check("t1_c1_addr", 32'(mem_addr), 32'h0);
    check("t1_c1_vld",  32'(instr_valid), 32'h0);
    check("b_c1_addr",  32'(b_mem_addr), 32'hFF);
    check("b_c1_fpc",   b_fetch_pc, 32'h3FC);
    nxt();
    settle();
    for (int k = 0; k < 6; k++) begin
      check("t1_vld",  32'(instr_valid), 32'h1);
      check("t1_ipc",  instr_pc, 32'(4 * k));
      check("t1_out",  instr_out, 32'hCAFE_0000 + 32'(k));
      check("t1_addr", 32'(mem_addr), 32'(k + 1));
      check("t1_cnt",  32'(queue_count), 32'h1);
      if (k == 0) begin
        check("b_ipc0",  b_instr_pc, 32'h3FC);
        check("b_addr0", 32'(b_mem_addr), 32'h00);
      end
      if (k == 1) begin
        check("b_ipc1",  b_instr_pc, 32'h400);
        check("b_out1",  b_instr_out, 32'hCAFE_0000);
        check("b_addr1", 32'(b_mem_addr), 32'h01);
      end
      nxt();
      settle();
    end

    // ---- T2: ready=0, 1-wait memory, fill to DEPTH, then drain ----
    do_reset(1, 1'b0);
    rst = 1'b0;
    settle();
    ack_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      if (mem_req && mem_ack) ack_cnt++;
      nxt();
      settle();
    end
    check("t2_acks", 32'(ack_cnt), 32'd4);
    check("t2_req",  32'(mem_req), 32'h0);
    check("t2_cnt",  32'(queue_count), 32'd4);
    check("t2_ipc",  instr_pc, 32'h0);
    instr_ready = 1'b1;
    settle();
    for (int k = 0; k < 5; k++) begin
      check("t2_pop_vld", 32'(instr_valid), 32'h1);
      check("t2_pop_ipc", instr_pc, 32'(4 * k));
      if (k == 1) begin
        check("t2_refetch_req",  32'(mem_req), 32'h1);
        check("t2_refetch_addr", 32'(mem_addr), 32'h4);
      end
      nxt();
      settle();
    end

    // ---- T3: 3 wait states, redirect while request to 0x8 is outstanding ----
    do_reset(3, 1'b1);
    rst = 1'b0;
    settle();
    wait_addr(8'h2, 40);
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    settle();
    check("t3_noack", 32'(mem_ack), 32'h0);
    nxt();
    redirect_valid = 1'b0;
    settle();
    check("t3_drain_addr", 32'(mem_addr), 32'h2);
    check("t3_drain_req",  32'(mem_req), 32'h1);
    check("t3_fpc",        fetch_pc, 32'h40);
    check("t3_flush",      32'(instr_valid), 32'h0);
    nxt();
    settle();
    check("t3_ack",      32'(mem_ack), 32'h1);
    check("t3_ack_addr", 32'(mem_addr), 32'h2);
    nxt();
    settle();
    check("t3_new_addr", 32'(mem_addr), 32'h10);
    check("t3_discard",  32'(instr_valid), 32'h0);
    wait_valid(10);
    check("t3_ipc", instr_pc, 32'h40);
    check("t3_out", instr_out, 32'hCAFE_0010);

    // ---- T4: redirect with ack and pop in the same cycle, 3 queued ----
    do_reset(0, 1'b0);
    rst = 1'b0;
    settle();
    nxt();
    nxt();
    nxt();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    settle();
    check("t4_cnt3", 32'(queue_count), 32'd3);
    check("t4_ack",  32'(mem_ack), 32'h1);
    check("t4_ipc",  instr_pc, 32'h0);
    nxt();
    redirect_valid = 1'b0;
    settle();
    check("t4_cnt0", 32'(queue_count), 32'd0);
    check("t4_vld",  32'(instr_valid), 32'h0);
    check("t4_addr", 32'(mem_addr), 32'h80);
    check("t4_fpc",  fetch_pc, 32'h200);
    wait_valid(10);
    check("t4_tgt_ipc", instr_pc, 32'h200);

    // ---- T6: reset asserted mid-REQ with two entries queued ----
    do_reset(1, 1'b0);
    rst = 1'b0;
    settle();
    nxt();
    nxt();
    nxt();
    nxt();
    settle();
    check("t6_cnt2", 32'(queue_count), 32'd2);
    check("t6_req",  32'(mem_req), 32'h1);
    rst = 1'b1;
    nxt();
    settle();
    check_reset_vals("t6");
    rst = 1'b0;
    settle();
    check("t6_restart_req",  32'(mem_req), 32'h1);
    check("t6_restart_addr", 32'(mem_addr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
